wb_rr_arbiter: RTL and testbench

- Round-robin arbiter that lets N Wishbone masters share one peripheral Wishbone bus. Typical masters: the picorv32 SoC base and a DMA engine (USB/audio sample mover).
- Sits between the masters and the existing per-peripheral cyc/ack decode. Grants exactly one master at a time and forwards its cycle to the downstream bus.
- Includes a bus-timeout watchdog, so a stalled slave cannot deadlock the system.

---
 rtl/wb_rr_arbiter_if.sv | 35 +++
 rtl/wb_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N cyc-only Wishbone masters, the round-robin arbiter and one downstream bus.
// The slave modport is the arbiter's view; the master modport is the view of the masters plus the downstream slave.
interface wb_rr_arbiter_if #(
  parameter int N     = 2,
  parameter int WB_DW = 32,
  parameter int WB_AW = 16,
  parameter int WB_MW = WB_DW / 8
);
  logic [N*WB_AW-1:0] m_addr;
  logic [N*WB_DW-1:0] m_wdata;
  logic [N*WB_MW-1:0] m_wmsk;
  logic [N-1:0]       m_we;
  logic [N-1:0]       m_cyc;
  logic [N-1:0]       m_ack;
  logic [N-1:0]       m_err;
  logic [WB_DW-1:0]   m_rdata;
  logic [WB_AW-1:0]   s_addr;
  logic [WB_DW-1:0]   s_wdata;
  logic [WB_MW-1:0]   s_wmsk;
  logic               s_we;
  logic               s_cyc;
  logic               s_ack;
  logic [WB_DW-1:0]   s_rdata;
  logic [N-1:0]       grant;

  modport master (
    output m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_ack, s_rdata,
    input  m_ack, m_err, m_rdata, s_addr, s_wdata, s_wmsk, s_we, s_cyc, grant
  );

  modport slave (
    input  m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_ack, s_rdata,
    output m_ack, m_err, m_rdata, s_addr, s_wdata, s_wmsk, s_we, s_cyc, grant
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one cyc-only Wishbone bus among N masters, with a bus-timeout watchdog.
// Handshake: a master holds m_cyc and its payload until m_ack; s_ack is a one-cycle pulse; m_err only ever accompanies m_ack.
module wb_rr_arbiter #(
  parameter int N       = 2,
  parameter int WB_DW   = 32,
  parameter int WB_AW   = 16,
  parameter int WB_MW   = WB_DW / 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  wb_rr_arbiter_if.slave wb,
  output logic dbg_state_o
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [LW-1:0]   last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]   gidx, pick, idx;
  logic            found, g_cyc, cnt_hit, to_err;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) gidx = LW'(i);
    end
  end

  // Search starts just after the last owner, so the previous owner ranks lowest.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last_q) + k) % N);
      if (!found && wb.m_cyc[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign g_cyc   = (state_q == BUS) && wb.m_cyc[gidx];
  assign cnt_hit = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT));
  assign to_err  = g_cyc && cnt_hit && !wb.s_ack;

  always_comb begin
    wb.s_addr  = '0;
    wb.s_wdata = '0;
    wb.s_wmsk  = '0;
    wb.s_we    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        wb.s_addr  = wb.m_addr[i*WB_AW +: WB_AW];
        wb.s_wdata = wb.m_wdata[i*WB_DW +: WB_DW];
        wb.s_wmsk  = wb.m_wmsk[i*WB_MW +: WB_MW];
        wb.s_we    = wb.m_we[i];
      end
    end
  end

  // The timeout cycle already withdraws s_cyc; a late s_ack in that cycle still completes normally.
  assign wb.s_cyc   = g_cyc && !cnt_hit;
  assign wb.m_ack   = grant_q & {N{g_cyc && (wb.s_ack || cnt_hit)}};
  assign wb.m_err   = grant_q & {N{to_err}};
  assign wb.m_rdata = to_err ? {WB_DW{1'b1}} : wb.s_rdata;
  assign wb.grant   = grant_q;
  assign dbg_state_o = (state_q == BUS);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUS;
          grant_d = N'(1) << pick;
          cnt_d   = '0;
        end
      end
      BUS: begin
        // Completion, abort and timeout all release the bus and demote the owner.
        if (!g_cyc || wb.s_ack || cnt_hit) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench for wb_rr_arbiter: a round-robin reference model predicts completion order into a queue,
// and a monitor pops and compares on every master acknowledge.
module tb_wb_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int MW  = DW / 8;
  localparam int TMO = 255;
  localparam int TW  = 8;
  localparam int EW  = 2 + 1 + DW + AW + DW + MW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.N(N), .WB_DW(DW), .WB_AW(AW), .WB_MW(MW)) bus ();

  wb_rr_arbiter #(
    .N(N), .WB_DW(DW), .WB_AW(AW), .WB_MW(MW), .TIMEOUT(TMO), .TO_W(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb(bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int last_m;
  bit mute;
  int wcnt, dly;
  bit prev_ack;
  int mon_id;
  logic [EW-1:0] mon_act, mon_exp;

  logic [AW-1:0] st_addr[8];
  logic [DW-1:0] st_wd[8];
  logic [MW-1:0] st_wm[8];
  bit            st_we[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first requester after the last completer, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [MW-1:0] wm, input bit we);
    bus.m_addr[i*AW +: AW]  = a;
    bus.m_wdata[i*DW +: DW] = wd;
    bus.m_wmsk[i*MW +: MW]  = wm;
    bus.m_we[i]             = we;
  endtask

  task automatic push_txn(input int i, input bit err, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [MW-1:0] wm, input bit we);
    logic [DW-1:0] rd;
    rd = err ? {DW{1'b1}} : {~a, a};
    exp_q.push_back({2'(i), err, rd, a, wd, wm, we});
  endtask

  task automatic new_txn(input int i, input bit err);
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    bit we;
    a  = AW'($urandom);
    wd = $urandom;
    wm = MW'($urandom);
    we = 1'($urandom_range(0, 1));
    drive_master(i, a, wd, wm, we);
    push_txn(i, err, a, wd, wm, we);
  endtask

  task automatic wait_ack_drop(input int i);
    int t;
    bit got;
    t = 0;
    got = 1'b0;
    while (t < 2000 && !got) begin
      @(negedge clk);
      if (bus.m_ack[i]) got = 1'b1;
      else t++;
    end
    check($sformatf("ack_wait_m%0d", i), got, 1'b1);
    @(posedge clk);
    #1 bus.m_cyc[i] = 1'b0;
  endtask

  task automatic run_phase(input logic [N-1:0] mask);
    int order[$];
    logic [N-1:0] rem;
    int cur;
    rem = mask;
    cur = last_m;
    while (rem != '0) begin
      cur = rr_pick(cur, rem);
      order.push_back(cur);
      rem[cur] = 1'b0;
    end
    @(posedge clk);
    #1;
    foreach (order[q]) new_txn(order[q], 1'b0);
    last_m = order[order.size() - 1];
    bus.m_cyc = bus.m_cyc | mask;
    for (int q = 0; q < order.size(); q++) begin
      automatic int j = order[q];
      fork
        wait_ack_drop(j);
      join_none
    end
    @(posedge clk);
    @(negedge clk);
    check("latency_scyc", bus.s_cyc, 1'b1);
    check("first_grant", bus.grant, N'(1) << order[0]);
    wait fork;
  endtask

  task automatic stream_master(input int id, input int t0);
    for (int t = t0; t < 8; t += 2) begin
      if (t != t0) begin
        @(posedge clk);
        #1;
      end
      drive_master(id, st_addr[t], st_wd[t], st_wm[t], st_we[t]);
      bus.m_cyc[id] = 1'b1;
      wait_ack_drop(id);
    end
  endtask

  task automatic run_stream(input int a, input int b);
    int f, s;
    f = rr_pick(last_m, (N'(1) << a) | (N'(1) << b));
    s = (f == a) ? b : a;
    for (int t = 0; t < 8; t++) begin
      st_addr[t] = AW'($urandom);
      st_wd[t]   = $urandom;
      st_wm[t]   = MW'($urandom);
      st_we[t]   = 1'($urandom_range(0, 1));
      push_txn((t % 2 == 0) ? f : s, 1'b0, st_addr[t], st_wd[t], st_wm[t], st_we[t]);
    end
    last_m = s;
    @(posedge clk);
    #1;
    fork
      stream_master(f, 0);
      stream_master(s, 1);
    join
  endtask

  task automatic run_timeout(input int x);
    int n, t;
    mute = 1'b1;
    @(posedge clk);
    #1;
    new_txn(x, 1'b1);
    last_m = x;
    bus.m_cyc[x] = 1'b1;
    fork
      wait_ack_drop(x);
    join_none
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.s_cyc && t < 10);
    n = 0;
    while (bus.s_cyc && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("timeout_scyc_len", n, TMO);
    wait fork;
    mute = 1'b0;
  endtask

  task automatic run_abort(input int a, input int b);
    logic [N-1:0] mask;
    int w, o;
    mask = (N'(1) << a) | (N'(1) << b);
    w = rr_pick(last_m, mask);
    o = (w == a) ? b : a;
    mute = 1'b1;
    @(posedge clk);
    #1;
    drive_master(w, AW'($urandom), $urandom, MW'($urandom), 1'b1);
    new_txn(o, 1'b0);
    last_m = o;
    bus.m_cyc = bus.m_cyc | mask;
    fork
      wait_ack_drop(o);
    join_none
    @(posedge clk);
    @(negedge clk);
    check("abort_owner", bus.grant, N'(1) << w);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 bus.m_cyc[w] = 1'b0;
    @(negedge clk);
    check("abort_scyc_drop", bus.s_cyc, 1'b0);
    check("abort_no_ack", bus.m_ack, '0);
    mute = 1'b0;
    @(negedge clk);
    check("abort_idle_gap", bus.grant, '0);
    @(negedge clk);
    check("abort_next_owner", bus.grant, N'(1) << o);
    wait fork;
  endtask

  task automatic run_reset_mid();
    int t;
    mute = 1'b1;
    @(posedge clk);
    #1;
    drive_master(2, AW'($urandom), $urandom, MW'($urandom), 1'b1);
    bus.m_cyc[2] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.s_cyc && t < 10);
    check("reset_pre_scyc", bus.s_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_scyc", bus.s_cyc, 1'b0);
    check("reset_grant", bus.grant, '0);
    check("reset_ack", bus.m_ack, '0);
    check("reset_state", dbg_state, 1'b0);
    bus.m_cyc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_m = N - 1;
    mute = 1'b0;
  endtask

  // Downstream slave: random ack delay, read data derived from the address.
  initial begin
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    wcnt = 0;
    dly = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.s_ack = 1'b0;
      bus.s_rdata = $urandom;
      if (!rst_n || mute || !bus.s_cyc) begin
        wcnt = 0;
      end else begin
        if (wcnt == 0) dly = $urandom_range(0, 3);
        if (wcnt == dly) begin
          bus.s_ack = 1'b1;
          bus.s_rdata = {~bus.s_addr, bus.s_addr};
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack = 1'b0;
    end else begin
      check("ack_onehot_err_qual", {$onehot0(bus.m_ack), ((bus.m_err & ~bus.m_ack) == '0)}, 2'b11);
      if (prev_ack) check("idle_gap", {bus.s_cyc, bus.grant}, '0);
      prev_ack = |bus.m_ack;
      if (|bus.m_ack) begin
        mon_id = 0;
        for (int i = 0; i < N; i++) if (bus.m_ack[i]) mon_id = i;
        mon_act = {2'(mon_id), bus.m_err[mon_id], bus.m_rdata, bus.s_addr, bus.s_wdata, bus.s_wmsk, bus.s_we};
        check("ack_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("ack_payload", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=done", checks);
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.m_addr = '0;
    bus.m_wdata = '0;
    bus.m_wmsk = '0;
    bus.m_we = '0;
    bus.m_cyc = '0;
    mute = 1'b0;
    last_m = N - 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {bus.s_cyc, bus.s_we, bus.m_ack, bus.m_err, bus.grant, dbg_state}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {bus.s_cyc, bus.s_addr, bus.grant, dbg_state}, '0);

    run_phase(4'b0001);
    run_stream(0, 1);
    run_phase(4'b1000);
    run_phase(4'b1010);
    run_timeout($urandom_range(0, N - 1));
    run_phase(4'b0100);
    run_abort(2, 0);
    for (int r = 0; r < 25; r++) run_phase(N'($urandom_range(1, (1 << N) - 1)));
    run_abort(1, 3);
    run_reset_mid();
    run_phase(4'b1001);
    for (int r = 0; r < 5; r++) run_phase(N'($urandom_range(1, (1 << N) - 1)));

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
